// File: rtl/lsu_mem_ctrl_if.sv
// Pipeline request/response and data-memory request/grant/response signals.
// The controller uses the slave view; the pipeline and memory side use the master view.
interface lsu_mem_ctrl_if #(
  parameter int DWIDTH = 32
);
  logic              req_valid;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [DWIDTH-1:0] req_addr;
  logic [DWIDTH-1:0] req_wdata;
  logic              busy;
  logic              done;
  logic              err;
  logic [DWIDTH-1:0] load_word;
  logic              mem_req;
  logic              mem_we;
  logic [DWIDTH-1:0] mem_addr;
  logic [3:0]        mem_be;
  logic [DWIDTH-1:0] mem_wdata;
  logic              mem_gnt;
  logic              mem_rvalid;
  logic [DWIDTH-1:0] mem_rdata;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata,
    output busy, done, err, load_word,
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata,
    output mem_gnt, mem_rvalid, mem_rdata,
    input  busy, done, err, load_word,
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );
endinterface

// File: rtl/lsu_mem_ctrl.sv
// Load/store controller: alignment check, word-addressed memory request with byte
// enables and lane-replicated store data, right-justified load data return.
module lsu_mem_ctrl #(
  parameter int DWIDTH = 32
) (
  input logic           i_clk,
  input logic           i_rst_n,
  lsu_mem_ctrl_if.slave io_bus
);

  if (DWIDTH != 32) begin : g_width_chk
    $error("lsu_mem_ctrl supports DWIDTH=32 only");
  end

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP} state_t;

  state_t            r_state, w_next;
  logic              r_we;
  logic [1:0]        r_size;
  logic [1:0]        r_off;
  logic              r_done, r_err;
  logic [DWIDTH-1:0] r_load_word;
  logic              r_mem_we;
  logic [DWIDTH-1:0] r_mem_addr;
  logic [3:0]        r_mem_be;
  logic [DWIDTH-1:0] r_mem_wdata;

  logic [1:0]        w_size;
  logic              w_f3_ok, w_aligned, w_accept, w_reject;
  logic [3:0]        w_be;
  logic [DWIDTH-1:0] w_wdata, w_shifted, w_load;

  assign w_size = io_bus.req_funct3[1:0];

  always_comb begin
    w_f3_ok   = 1'b0;
    w_aligned = 1'b0;
    case (io_bus.req_funct3)
      3'd0, 3'd1, 3'd2: w_f3_ok = 1'b1;
      3'd4, 3'd5:       w_f3_ok = !io_bus.req_we;
      default:          w_f3_ok = 1'b0;
    endcase
    case (w_size)
      2'd0:    w_aligned = 1'b1;
      2'd1:    w_aligned = !io_bus.req_addr[0];
      2'd2:    w_aligned = (io_bus.req_addr[1:0] == 2'b00);
      default: w_aligned = 1'b0;
    endcase
  end

  assign w_accept = (r_state == S_IDLE) && io_bus.req_valid && w_f3_ok && w_aligned;
  assign w_reject = (r_state == S_IDLE) && io_bus.req_valid && !(w_f3_ok && w_aligned);

  // Byte enables only qualify writes; loads always fetch the whole word.
  always_comb begin
    w_be    = 4'b0000;
    w_wdata = io_bus.req_wdata;
    case (w_size)
      2'd0: begin
        w_be    = 4'b0001 << io_bus.req_addr[1:0];
        w_wdata = {4{io_bus.req_wdata[7:0]}};
      end
      2'd1: begin
        w_be    = 4'b0011 << io_bus.req_addr[1:0];
        w_wdata = {2{io_bus.req_wdata[15:0]}};
      end
      default: begin
        w_be    = 4'b1111;
        w_wdata = io_bus.req_wdata;
      end
    endcase
    if (!io_bus.req_we) w_be = 4'b0000;
  end

  assign w_shifted = io_bus.mem_rdata >> {r_off, 3'b000};

  always_comb begin
    case (r_size)
      2'd0:    w_load = {{(DWIDTH-8){1'b0}}, w_shifted[7:0]};
      2'd1:    w_load = {{(DWIDTH-16){1'b0}}, w_shifted[15:0]};
      default: w_load = w_shifted;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = S_REQ;
      S_REQ:   if (io_bus.mem_gnt) w_next = r_we ? S_IDLE : S_RESP;
      S_RESP:  if (io_bus.mem_rvalid) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_we        <= 1'b0;
      r_size      <= 2'd0;
      r_off       <= 2'd0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_load_word <= '0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_be    <= 4'b0000;
      r_mem_wdata <= '0;
    end else begin
      r_err  <= w_reject;
      r_done <= ((r_state == S_REQ) && io_bus.mem_gnt && r_we) ||
                ((r_state == S_RESP) && io_bus.mem_rvalid);
      if (w_accept) begin
        r_we        <= io_bus.req_we;
        r_size      <= w_size;
        r_off       <= io_bus.req_addr[1:0];
        r_mem_we    <= io_bus.req_we;
        r_mem_addr  <= {io_bus.req_addr[DWIDTH-1:2], 2'b00};
        r_mem_be    <= w_be;
        r_mem_wdata <= w_wdata;
      end
      if ((r_state == S_RESP) && io_bus.mem_rvalid) r_load_word <= w_load;
    end
  end

  assign io_bus.busy      = (r_state != S_IDLE);
  assign io_bus.mem_req   = (r_state == S_REQ);
  assign io_bus.done      = r_done;
  assign io_bus.err       = r_err;
  assign io_bus.load_word = r_load_word;
  assign io_bus.mem_we    = r_mem_we;
  assign io_bus.mem_addr  = r_mem_addr;
  assign io_bus.mem_be    = r_mem_be;
  assign io_bus.mem_wdata = r_mem_wdata;

endmodule

// File: doc/lsu_mem_ctrl.md
# lsu_mem_ctrl

Load/store memory controller in the execute-to-writeback path. It accepts one load or store per transaction from the pipeline and checks alignment. It drives a request/grant/response data-memory port with word addresses and byte enables. For loads it returns the addressed byte, halfword or word right-justified on `load_word`, which feeds the load extender that applies sign or zero extension from funct3.

## Interface
- `DWIDTH`, 32: data and address width. Only 32 is supported; elaboration fails otherwise.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `req_valid`  in  1  pipeline request; sampled only in IDLE.
- `req_we`  in  1  1 = store, 0 = load.
- `req_funct3`  in  3  RISC-V load/store funct3: 0 b, 1 h, 2 w, 4 bu, 5 hu.
- `req_addr`  in  DWIDTH  byte address.
- `req_wdata`  in  DWIDTH  store data; the low byte or halfword is significant.
- `busy`  out  1  transaction in flight (state != IDLE); pipeline stalls on it.
- `done`  out  1  one-cycle pulse when the transaction completes.
- `err`  out  1  one-cycle pulse for a misaligned access or illegal funct3; no memory access is made.
- `load_word`  out  DWIDTH  right-justified load data, valid while `done` is high on a load.
- `mem_req`  out  1  memory request.
- `mem_we`  out  1  write enable.
- `mem_addr`  out  DWIDTH  word address: `{addr[31:2], 2'b00}`.
- `mem_be`  out  4  byte enables.
- `mem_wdata`  out  DWIDTH  lane-replicated store data.
- `mem_gnt`  in  1  memory accepts the request in this cycle.
- `mem_rvalid`  in  1  read data valid.
- `mem_rdata`  in  DWIDTH  read data, whole word.

## Operation
- States: IDLE, REQ, RESP.
- Acceptance, in IDLE with `req_valid=1`:
  - Legal funct3: loads 0,1,2,4,5; stores 0,1,2.
  - Halfword accesses require `addr[0]=0`. Word accesses require `addr[1:0]=0`.
  - Illegal or misaligned: `err` pulses the next cycle and the state stays IDLE.
  - Otherwise: register `we`, `funct3`, `off=addr[1:0]` and the memory fields, then go to REQ.
- Byte enables:
  - byte: `4'b0001<<off`
  - half: `4'b0011<<off`
  - word: `4'b1111`
- Store data lanes:
  - byte: `{4{wdata[7:0]}}`
  - half: `{2{wdata[15:0]}}`
  - word: `wdata`
- REQ:
  - `mem_req=1`. All `mem_*` outputs are held stable until the cycle in which `mem_gnt=1`.
  - On grant with a store: `done` pulses the next cycle and the state returns to IDLE.
  - On grant with a load: go to RESP.
- RESP:
  - Wait for `mem_rvalid`. Then register `load_word = mem_rdata >> (8*off)`.
  - Masking of `load_word`:
    - byte: bits 31:8 are zero.
    - half: bits 31:16 are zero.
    - word: unmasked.
  - `done` pulses with `load_word` valid, and the state returns to IDLE.
- `mem_rvalid` outside RESP and `mem_gnt` outside REQ are ignored.
- `req_valid` is ignored while `busy=1`. Captured fields are immune to input changes.
- `load_word` holds its value until the next load completes.

## Timing
- Reset, on an edge with `rst_n=0`:
  - State becomes IDLE.
  - `busy`, `done`, `err`, `mem_req`, `mem_we` become 0.
  - `mem_be` becomes 0.
  - `mem_addr`, `mem_wdata`, `load_word` become 0.
- Reset mid-transaction abandons the transaction. `mem_req` is 0 from the next cycle, and a later `rvalid` is ignored.
- Acceptance at edge N: `busy` and `mem_req` are high from cycle N+1.
- Load, best case (grant in N+1, rvalid in N+2): `done` and `load_word` appear in cycle N+3.
- Store, best case (grant in N+1): `done` appears in N+2.
- `busy` drops in the same cycle `done` is high, so the pipeline may issue again in the `done` cycle.
- Error: `err` is high in cycle N+1, `busy` never rises, and `mem_req` never rises.
- Back-to-back: a new request presented in the `done` cycle is accepted at that edge.

## Test plan
- Load byte: lb with addr=0x103 and rdata=0xAABBCCDD.
  - Expect `mem_addr=0x100` and `mem_be=0000` (be is not driven for loads).
  - Expect `load_word=0x000000AA`, with `done` 3 cycles after acceptance.
- Store halfword: sh with addr=0x22 and wdata=0x1234ABCD.
  - Expect `mem_be=1100` and `mem_wdata=0xABCDABCD`.
  - Expect `done` at N+2.
- Misalignment: lw at 0x101 and lh at 0x3.
  - Expect an `err` pulse, no `mem_req`, and `busy=0`.
  - Repeat with a load using funct3=3; the same response is required.
- Grant stall: hold `mem_gnt=0` for 5 cycles, then toggle `req_addr` and `req_wdata`.
  - Expect the `mem_*` outputs to stay stable.
  - After grant, expect `done` with the original data.
- Reset and back-to-back:
  - Assert `rst_n=0` in RESP. Expect all outputs at 0 the next cycle, and a subsequent `mem_rvalid` produces no `done`.
  - Then issue lw followed by sb in the `done` cycle. Expect the second transaction to start immediately.
